i2s_receiver: RTL and testbench
===============================

// Module: i2s_receiver
// PURPOSE
//  I2S slave deserializer: oversamples external BCLK/LRCLK/SDATA on clk_i and rebuilds
//  stereo PCM words. Sits directly downstream of i2s_transmitter (loopback, capture from
//  codec ADC); outputs a left/right pair with a 1-cycle valid strobe per audio frame.
//  Standard I2S framing: 1-BCLK delay after LRCLK edge, MSB first, LRCLK 0 = left, 1 = right.
// PARAMETERS
//  AUDIO_WORD_LEN   24   bits captured per channel slot (MSB first)
//  SLOT_LEN_MAX     32   max BCLKs per LRCLK half-period; bit counter saturates here
//  BCLK_TIMEOUT     64   clk_i cycles without a BCLK rising edge before unlock
// PORTS
//  clk_i          in   1               system clock (40 MHz)
//  rst_i          in   1               synchronous reset, active-high
//  enable_i       in   1               0: hold all state, ignore pins, no strobes
//  i2s_bclk_i     in   1               async serial bit clock
//  i2s_lrclk_i    in   1               async word select
//  i2s_data_i     in   1               async serial data
//  left_o         out  AUDIO_WORD_LEN  last complete left word
//  right_o        out  AUDIO_WORD_LEN  last complete right word
//  valid_o        out  1               1-cycle pulse: new left/right pair on outputs
//  locked_o       out  1               framing locked
//  frame_err_o    out  1               1-cycle pulse: framing violation detected
// BEHAVIOUR
//  - Reset: all outputs 0; shift reg, bit_cnt, lr_prev, watchdog, pending-left cleared.
//  - Input path: 2-FF sync on all three pins, then BCLK rise detect (sync'd 0->1). Pin edge
//    to internal bclk_rise = 3 clk. Requires BCLK high and low >= 3 clk_i each.
//  - On each bclk_rise (enable_i=1), sample lr and sd together:
//    * lr != lr_prev: delay bit, discard sd; bit_cnt<=1; lr_prev<=lr. If bit_cnt was
//      in 1..AUDIO_WORD_LEN (word incomplete) -> frame_err_o, locked_o<=0, drop word.
//    * else if 1 <= bit_cnt <= AUDIO_WORD_LEN: shift sd into LSB; bit_cnt++.
//    * else: padding bit, ignored; bit_cnt++ saturating at SLOT_LEN_MAX.
//  - Word complete (bit_cnt reaches AUDIO_WORD_LEN+1, same cycle as last shift): lr=0 ->
//    left_o<=word, pending_left<=1; lr=1 and pending_left -> right_o<=word, valid_o=1 next
//    clk, pending_left<=0, locked_o<=1. Right word without pending left: discarded, no error.
//  - First LRCLK edge after reset/unlock only aligns (bit_cnt was 0): no error flagged.
//  - Watchdog: counts clk_i since last bclk_rise; at BCLK_TIMEOUT -> locked_o<=0,
//    bit_cnt<=0, pending_left<=0 (no frame_err_o). Counter saturates.
//  - left_o/right_o hold last values when unlocked; valid_o never fires while a pair is
//    incomplete. valid_o and frame_err_o never both 1.
//  - enable_i=0: synchronizers keep running, edges ignored, watchdog frozen.
//  - Reset mid-word: partial word lost, next LRCLK edge realigns as after power-up.
// STRUCTURE
//  - i2s_pkg: AUDIO_WORD_LEN default, typedef enum logic {CH_LEFT=1'b0, CH_RIGHT=1'b1}
//    i2s_ch_e, typedef logic [AUDIO_WORD_LEN-1:0] audio_word_t; shared with i2s_transmitter.
//  - Sub-module i2s_sync_edge: 2-FF synchronizer + rising-edge pulse, instantiated for BCLK;
//    LRCLK/DATA use its synchronized level output only.
//  - Top: deserializer shift reg, bit counter, pairing logic, watchdog.
// TESTING
//  1 Loopback from i2s_transmitter (CLK_DIVISION=14), audio_data_i=24'hA5A5A5 -> after
//    2nd frame left_o=right_o=24'hA5A5A5, valid_o pulse every 64 BCLK (896 clk).
//  2 BFM drives left 24'h800001, right 24'h7FFFFE, MSB first, 1-bit delay -> exact words,
//    valid_o one clk after last right-bit bclk_rise (+3 sync), locked_o=1.
//  3 LRCLK toggles after 10 bits of left slot -> frame_err_o pulse, locked_o=0, no
//    valid_o; next two clean slots -> relock, correct pair.
//  4 Stop BCLK for 64 clk_i -> locked_o falls, no frame_err_o; outputs hold; restart ->
//    first LRCLK edge aligns silently, valid after a full L+R pair.
//  5 rst_i pulsed mid right-slot -> all outputs 0 next clk, no valid_o until full pair.
//  6 enable_i=0 for one full frame -> no valid_o, state frozen; re-enable -> resumes.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: word width, channel encoding and word type shared by the I2S receiver and transmitter
package i2s_pkg;
  localparam int AUDIO_WORD_LEN = 24;
  typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} i2s_ch_e;
  typedef logic [AUDIO_WORD_LEN-1:0] audio_word_t;
endpackage

// File: rtl/i2s_sync_edge.sv
// i2s_sync_edge: 2-FF synchronizer with registered rising-edge pulse on edge_i; lvl_i bits get equal latency
module i2s_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         edge_i,
  input  logic [W-1:0] lvl_i,
  output logic [W-1:0] lvl_o,
  output logic         rise_o
);
  logic         e_meta_q, e_sync_q, e_prev_q, rise_q;
  logic [W-1:0] l_meta_q, l_sync_q, l_out_q;
  logic         rise_d;
  assign rise_d = e_sync_q & ~e_prev_q;
  // synchronizer chain; the level stage lines up with the registered edge pulse
  always_ff @(posedge clk_i) begin
    e_meta_q <= edge_i;
    e_sync_q <= e_meta_q;
    e_prev_q <= e_sync_q;
    rise_q   <= rise_d;
    l_meta_q <= lvl_i;
    l_sync_q <= l_meta_q;
    l_out_q  <= l_sync_q;
  end
  assign lvl_o  = l_out_q;
  assign rise_o = rise_q;
endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver: oversampled I2S slave deserializer producing left/right PCM pairs
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int SLOT_LEN_MAX = 32,
  parameter int BCLK_TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        i2s_bclk_i,
  input  logic        i2s_lrclk_i,
  input  logic        i2s_data_i,
  output audio_word_t left_o,
  output audio_word_t right_o,
  output logic        valid_o,
  output logic        locked_o,
  output logic        frame_err_o
);
  localparam int CNT_W = $clog2(SLOT_LEN_MAX + 1);
  localparam int WD_W  = $clog2(BCLK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WORD_END = CNT_W'(AUDIO_WORD_LEN);
  localparam logic [CNT_W-1:0] SLOT_END = CNT_W'(SLOT_LEN_MAX);
  localparam logic [WD_W-1:0]  WD_END   = WD_W'(BCLK_TIMEOUT);
  logic [1:0]       pins_s;
  logic             lr_s, sd_s, bclk_rise, in_word;
  audio_word_t      shift_q, shift_d, left_q, left_d, right_q, right_d, word;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  i2s_ch_e          lr_prev_q, lr_prev_d;
  logic             pend_q, pend_d, locked_q, locked_d, valid_q, valid_d, err_q, err_d;
  i2s_sync_edge #(.W(2)) u_sync (
    .clk_i (clk_i),
    .edge_i(i2s_bclk_i),
    .lvl_i ({i2s_lrclk_i, i2s_data_i}),
    .lvl_o (pins_s),
    .rise_o(bclk_rise)
  );
  assign {lr_s, sd_s} = pins_s;
  // per BCLK rise: realign on LRCLK change, shift word bits, count padding; otherwise run the watchdog
  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    lr_prev_d = lr_prev_q;
    wd_d      = wd_q;
    pend_d    = pend_q;
    left_d    = left_q;
    right_d   = right_q;
    locked_d  = locked_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    word      = {shift_q[AUDIO_WORD_LEN-2:0], sd_s};
    in_word   = (cnt_q != '0) && (cnt_q <= WORD_END);
    if (enable_i && bclk_rise) begin
      wd_d = '0;
      if (lr_s != lr_prev_q) begin
        cnt_d     = CNT_W'(1);
        lr_prev_d = i2s_ch_e'(lr_s);
        if (in_word) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          pend_d   = 1'b0;
        end
      end else if (in_word) begin
        shift_d = word;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == WORD_END) begin
          if (lr_s == CH_LEFT) begin
            left_d = word;
            pend_d = 1'b1;
          end else if (pend_q) begin
            right_d  = word;
            valid_d  = 1'b1;
            pend_d   = 1'b0;
            locked_d = 1'b1;
          end
        end
      end else if (cnt_q != '0 && cnt_q < SLOT_END) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (enable_i) begin
      wd_d = (wd_q == WD_END) ? wd_q : wd_q + 1'b1;
      if (wd_q == WD_END) begin
        locked_d = 1'b0;
        cnt_d    = '0;
        pend_d   = 1'b0;
      end
    end
  end
  // state register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      lr_prev_q <= CH_LEFT;
      wd_q      <= '0;
      pend_q    <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
      locked_q  <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      lr_prev_q <= lr_prev_d;
      wd_q      <= wd_d;
      pend_q    <= pend_d;
      left_q    <= left_d;
      right_q   <= right_d;
      locked_q  <= locked_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end
  assign left_o      = left_q;
  assign right_o     = right_q;
  assign valid_o     = valid_q;
  assign locked_o    = locked_q;
  assign frame_err_o = err_q;
endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: randomized I2S slot driver with a slot-level reference model and event scoreboard
module tb_i2s_receiver;
  import i2s_pkg::*;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, bclk = 1'b0, lrclk = 1'b0, sdata = 1'b0;
  audio_word_t left_o, right_o;
  logic        valid_o, locked_o, frame_err_o;
  int          errors = 0, checks = 0, cyc = 0, end_cyc = 0;
  logic [48:0] obs_q[$], exp_q[$];
  bit          m_lr, m_aligned, m_complete, m_pending, m_locked;
  audio_word_t m_left, m_right;

  i2s_receiver dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .enable_i   (en),
    .i2s_bclk_i (bclk),
    .i2s_lrclk_i(lrclk),
    .i2s_data_i (sdata),
    .left_o     (left_o),
    .right_o    (right_o),
    .valid_o    (valid_o),
    .locked_o   (locked_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // record every strobe; a valid must follow the last right data bit by sync latency plus one
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (valid_o || frame_err_o) check("strobe_excl", 64'(valid_o & frame_err_o), 0);
      if (valid_o) begin
        obs_q.push_back({1'b1, left_o, right_o});
        check("valid_lat", 64'(cyc - end_cyc), 4);
      end
      if (frame_err_o) obs_q.push_back('0);
    end
  end

  // reference: one call per LRCLK slot, nbits = BCLKs seen in that slot including the delay bit
  task automatic model_slot(bit lr, audio_word_t w, int nbits);
    if (lr == m_lr) return;
    if (m_aligned && !m_complete) begin
      exp_q.push_back('0);
      m_locked  = 0;
      m_pending = 0;
    end
    m_lr       = lr;
    m_aligned  = 1;
    m_complete = nbits > AUDIO_WORD_LEN;
    if (!m_complete) return;
    if (!lr) begin
      m_left    = w;
      m_pending = 1;
    end else if (m_pending) begin
      m_right   = w;
      m_pending = 0;
      m_locked  = 1;
      exp_q.push_back({1'b1, m_left, w});
    end
  endtask

  task automatic send_slot(bit lr, audio_word_t w, int first, int last);
    for (int i = first; i <= last; i++) begin
      bclk  = 1'b0;
      lrclk = lr;
      if (i >= 1 && i <= AUDIO_WORD_LEN) sdata = w[AUDIO_WORD_LEN-i];
      else sdata = 1'($urandom_range(0, 1));
      repeat (4) @(negedge clk);
      bclk = 1'b1;
      if (lr && i == AUDIO_WORD_LEN) end_cyc = cyc;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic frame(audio_word_t l, audio_word_t r);
    model_slot(0, l, 32);
    send_slot(0, l, 0, 31);
    model_slot(1, r, 32);
    send_slot(1, r, 0, 31);
  endtask

  task automatic settle(string tag);
    repeat (8) @(negedge clk);
    check({tag, "_nevt"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) check({tag, "_evt"}, 64'(obs_q[i]), 64'(exp_q[i]));
    check({tag, "_locked"}, 64'(locked_o), 64'(m_locked));
    check({tag, "_left"}, 64'(left_o), 64'(m_left));
    check({tag, "_right"}, 64'(right_o), 64'(m_right));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    audio_word_t a, b;
    repeat (4) @(negedge clk);
    check("rst_outs", 64'({left_o, right_o, valid_o, locked_o, frame_err_o}), 0);
    rst = 1'b0;
    en  = 1'b1;
    frame(audio_word_t'($urandom), audio_word_t'($urandom));
    frame(24'h800001, 24'h7FFFFE);
    settle("basic");
    for (int k = 0; k < 4; k++) frame(audio_word_t'($urandom), audio_word_t'($urandom));
    settle("rand");
    a = audio_word_t'($urandom);
    model_slot(0, a, 11);
    send_slot(0, a, 0, 10);
    model_slot(1, a, 32);
    send_slot(1, a, 0, 31);
    check("ferr_unlock", 64'(locked_o), 64'(m_locked));
    frame(audio_word_t'($urandom), audio_word_t'($urandom));
    settle("ferr");
    frame(audio_word_t'($urandom), audio_word_t'($urandom));
    bclk = 1'b0;
    repeat (80) @(negedge clk);
    m_aligned = 0;
    m_locked  = 0;
    m_pending = 0;
    settle("timeout");
    frame(audio_word_t'($urandom), audio_word_t'($urandom));
    settle("relock");
    a = audio_word_t'($urandom);
    b = audio_word_t'($urandom);
    model_slot(0, a, 32);
    send_slot(0, a, 0, 31);
    model_slot(1, b, 16);
    send_slot(1, b, 0, 15);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid", 64'({left_o, right_o, valid_o, locked_o, frame_err_o}), 0);
    rst = 1'b0;
    m_lr = 0; m_aligned = 0; m_pending = 0; m_locked = 0; m_left = '0; m_right = '0;
    obs_q.delete();
    exp_q.delete();
    model_slot(1, b, 16);
    send_slot(1, b, 16, 31);
    frame(audio_word_t'($urandom), audio_word_t'($urandom));
    settle("rst");
    a = audio_word_t'($urandom);
    b = audio_word_t'($urandom);
    model_slot(0, a, 32);
    send_slot(0, a, 0, 31);
    model_slot(1, b, 32);
    send_slot(1, b, 0, 27);
    en = 1'b0;
    send_slot(1, b, 28, 31);
    send_slot(0, audio_word_t'($urandom), 0, 31);
    send_slot(1, audio_word_t'($urandom), 0, 27);
    check("en_frozen_locked", 64'(locked_o), 64'(m_locked));
    en = 1'b1;
    send_slot(1, b, 28, 31);
    frame(audio_word_t'($urandom), audio_word_t'($urandom));
    settle("enable");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
